// File: rtl/pe_sched_pkg.sv
// Shared types for the PE row scheduler: FSM state encoding and the
// kernel-row / kernel-column / channel triple produced by the sweep counter.
package pe_sched_pkg;

  // Widest R/C/Channel field the triple type can carry.
  localparam int unsigned RCC_MAX_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_VALID,
    SWEEP,
    DRAIN,
    SWITCH,
    GAP,
    DONE
  } state_e;

  typedef struct packed {
    logic [RCC_MAX_W-1:0] channel;
    logic [RCC_MAX_W-1:0] col;
    logic [RCC_MAX_W-1:0] row;
  } rcc_t;

endpackage

// File: rtl/pe_row_scheduler_rcc_counter.sv
// Three-level nested counter: channel innermost, column middle, row outermost.
// Each field returns to 0 at its terminal value.
module rcc_counter
  import pe_sched_pkg::*;
#(
  parameter int unsigned K      = 3,
  parameter int unsigned NEXT_N = 32
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output rcc_t rcc,
  output logic last,
  output logic wrap
);

  logic ch_last;
  logic col_last;
  logic row_last;

  assign ch_last  = (rcc.channel == RCC_MAX_W'(NEXT_N - 1));
  assign col_last = (rcc.col == RCC_MAX_W'(K - 1));
  assign row_last = (rcc.row == RCC_MAX_W'(K - 1));
  assign last     = ch_last & col_last & row_last;
  assign wrap     = en & last;

  // Advance the nested count by one triple per enabled cycle.
  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      rcc <= '0;
    end else if (en) begin
      rcc.channel <= ch_last ? '0 : rcc.channel + RCC_MAX_W'(1);
      if (ch_last) begin
        rcc.col <= col_last ? '0 : rcc.col + RCC_MAX_W'(1);
        if (col_last) begin
          rcc.row <= row_last ? '0 : rcc.row + RCC_MAX_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/pe_row_scheduler.sv
// Per-output-row scheduler: waits for a full row window, sweeps every
// (row, column, channel) triple of the kernel into the PE, drains, swaps the
// ping-pong buffers, idles for a gap and repeats until the layer is done.
module pe_row_scheduler
  import pe_sched_pkg::*;
#(
  parameter int unsigned K         = 3,
  parameter int unsigned NEXT_N    = 32,
  parameter int unsigned REAL_HOUT = 25,
  parameter int unsigned ROW_WIDTH = 10,
  parameter int unsigned DRAIN_CYC = 2,
  parameter int unsigned GAP_CYC   = 10
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  input  logic                      row_buffer_data_valid,
  input  logic                      pe_stall,
  output logic                      pe_ctrl_ready,
  output logic [2:0][ROW_WIDTH-1:0] R_C_Channel,
  output logic                      rcc_valid,
  output logic                      pe_buffer_switch,
  output logic [ROW_WIDTH-1:0]      row_cnt,
  output logic                      busy,
  output logic                      done
);

  if ((K > (2 ** ROW_WIDTH)) || (NEXT_N > (2 ** ROW_WIDTH)) || (ROW_WIDTH > RCC_MAX_W)) begin : g_bad_params
    $error("pe_row_scheduler: K and NEXT_N must not exceed 2**ROW_WIDTH (ROW_WIDTH <= RCC_MAX_W)");
  end

  state_e                      state_q;
  state_e                      state_d;
  logic [31:0]                 tmr_q;
  logic                        cnt_en;
  logic                        cnt_clr;
  logic                        cnt_last;
  logic                        cnt_wrap;
  rcc_t                        cnt_rcc;
  logic [2:0][ROW_WIDTH-1:0]   cur_rcc;
  logic [2:0][ROW_WIDTH-1:0]   hold_q;
  logic                        rcc_unused;

  assign cnt_en    = (state_q == SWEEP) && !pe_stall;
  assign cnt_clr   = (state_q == IDLE) && start;
  assign rcc_valid = cnt_en;
  assign busy      = (state_q != IDLE);

  rcc_counter #(
    .K      (K),
    .NEXT_N (NEXT_N)
  ) u_rcc_counter (
    .clk  (clk),
    .rstn (rstn),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .rcc  (cnt_rcc),
    .last (cnt_last),
    .wrap (cnt_wrap)
  );

  assign cur_rcc[0] = cnt_rcc.row[ROW_WIDTH-1:0];
  assign cur_rcc[1] = cnt_rcc.col[ROW_WIDTH-1:0];
  assign cur_rcc[2] = cnt_rcc.channel[ROW_WIDTH-1:0];
  assign rcc_unused = ^{cnt_rcc, cnt_last};

  // The counter wraps to 0 on the last beat, so the issued triple is captured
  // here to keep R_C_Channel steady once the sweep has finished.
  assign R_C_Channel = (state_q == SWEEP) ? cur_rcc : hold_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Cycles spent in the current state; restarts on every state change.
  always_ff @(posedge clk) begin
    if (!rstn || (state_d != state_q)) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_q + 32'd1;
    end
  end

  // Output rows completed in this layer.
  always_ff @(posedge clk) begin
    if (!rstn || cnt_clr) begin
      row_cnt <= '0;
    end else if (state_q == SWITCH) begin
      row_cnt <= row_cnt + ROW_WIDTH'(1);
    end
  end

  // Last triple handed to the PE.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      hold_q <= '0;
    end else if (cnt_en) begin
      hold_q <= cur_rcc;
    end
  end

  // Next-state and per-state outputs.
  always_comb begin
    state_d          = state_q;
    pe_ctrl_ready    = 1'b0;
    pe_buffer_switch = 1'b0;
    done             = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = WAIT_VALID;
      end
      WAIT_VALID: begin
        if (row_buffer_data_valid) state_d = SWEEP;
      end
      SWEEP: begin
        pe_ctrl_ready = 1'b1;
        if (cnt_wrap) state_d = (DRAIN_CYC != 0) ? DRAIN : SWITCH;
      end
      DRAIN: begin
        pe_ctrl_ready = 1'b1;
        if (tmr_q == 32'(DRAIN_CYC - 1)) state_d = SWITCH;
      end
      SWITCH: begin
        pe_ctrl_ready    = 1'b1;
        pe_buffer_switch = 1'b1;
        // With no gap the layer-end decision must see the row being completed now.
        if (GAP_CYC != 0) begin
          state_d = GAP;
        end else begin
          state_d = ((row_cnt + ROW_WIDTH'(1)) == ROW_WIDTH'(REAL_HOUT)) ? DONE : WAIT_VALID;
        end
      end
      GAP: begin
        if (tmr_q == 32'(GAP_CYC - 1)) begin
          state_d = (row_cnt == ROW_WIDTH'(REAL_HOUT)) ? DONE : WAIT_VALID;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
